// File: rtl/display_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl_pkg
// Shared constants for the multiplexed display scanner:
//   MAX_DIG   - largest number of digits the anode bus can drive (8)
//   NIB_W     - width of one hex digit nibble (4)
//   IDX_W     - width of a digit index (3)
//   ANODE_OFF - anode bus value with every digit dark (8'hFF, active-low)
// lead_digit() returns the index of the highest nonzero nibble of a 32-bit
// display word (0 when the word is all zero).
// -----------------------------------------------------------------------------
package display_scan_ctrl_pkg;

    localparam int MAX_DIG = 8;
    localparam int NIB_W   = 4;
    localparam int IDX_W   = 3;
    localparam logic [MAX_DIG-1:0] ANODE_OFF = 8'hFF;

    function automatic logic [IDX_W-1:0] lead_digit(input logic [MAX_DIG*NIB_W-1:0] word);
        logic [IDX_W-1:0] hi;
        hi = '0;
        for (int k = 0; k < MAX_DIG; k++) begin
            if (word[k*NIB_W +: NIB_W] != '0) begin
                hi = IDX_W'(k);
            end
        end
        return hi;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_timer.sv
// -----------------------------------------------------------------------------
// scan_timer
// Prescaler plus digit index for the display scanner.
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset
//   tick      - high in the cycle the prescaler holds CLK_DIV-1
//   idx       - current digit slot, 0..NUM_DIG-1, advances on tick
//   frame_end - tick in the last digit slot of a frame
// Runs continuously; nothing gates it.
// -----------------------------------------------------------------------------
module scan_timer
    import display_scan_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 50000,
    parameter int NUM_DIG = 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic             tick,
    output logic [IDX_W-1:0] idx,
    output logic             frame_end
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIG - 1);

    logic [CW-1:0] cnt;

    assign tick      = (cnt == CNT_LAST);
    assign frame_end = tick && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            if (tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
// Time-multiplexed hex display scanner with frame-synchronous updates.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-low reset
//   en       - display enable; low turns every anode off (scan keeps running)
//   upd_req  - one-cycle strobe capturing upd_data
//   upd_data - eight hex nibbles, nibble k for digit k
//   blank    - bit k blanks digit k
//   upd_ack  - one-cycle pulse after a captured value reaches the display
//   DN_A     - active-low anode enables (one low bit, or all high)
//   DIG      - nibble of the digit currently being driven
// Build option: define SCAN_LZS_EN to add leading-zero suppression (digits
// above the highest nonzero nibble go dark; digit 0 always stays lit).
//
// Update handshake: upd_req is a single-cycle strobe with no back-pressure.
// Each strobe overwrites the staging word (last one wins). The staged word is
// copied to the displayed shadow word only on the frame_end cycle, and upd_ack
// pulses for one cycle right after that copy. A strobe landing on frame_end
// itself is committed directly in that cycle.
// -----------------------------------------------------------------------------
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 50000,
    parameter int NUM_DIG = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     upd_req,
    input  logic [MAX_DIG*NIB_W-1:0] upd_data,
    input  logic [MAX_DIG-1:0]       blank,
    output logic                     upd_ack,
    output logic [MAX_DIG-1:0]       DN_A,
    output logic [NIB_W-1:0]         DIG
);

    logic [IDX_W-1:0]         idx;
    logic                     frame_end;
    logic                     tick_unused;  // tick is only needed inside the timer
    logic [MAX_DIG*NIB_W-1:0] staging;
    logic [MAX_DIG*NIB_W-1:0] shadow;
    logic                     pending;
    logic                     commit;
    logic [MAX_DIG-1:0]       blank_eff;
    logic [MAX_DIG-1:0]       anode_next;

    scan_timer #(
        .CLK_DIV (CLK_DIV),
        .NUM_DIG (NUM_DIG)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick_unused),
        .idx       (idx),
        .frame_end (frame_end)
    );

    assign commit = frame_end && (pending || upd_req);

    // Effective blanking: external mask, optionally widened by zero suppression
    // derived from the displayed (shadow) word so it changes only per frame.
    always_comb begin
        blank_eff = blank;
`ifdef SCAN_LZS_EN
        for (int k = 1; k < MAX_DIG; k++) begin
            if (IDX_W'(k) > lead_digit(shadow)) begin
                blank_eff[k] = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        anode_next = ANODE_OFF;
        if (en && !blank_eff[idx] && (int'(idx) < NUM_DIG)) begin
            anode_next[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            staging <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            upd_ack <= 1'b0;
            DN_A    <= ANODE_OFF;
            DIG     <= '0;
        end else begin
            DN_A    <= anode_next;
            DIG     <= shadow[NIB_W*idx +: NIB_W];
            upd_ack <= commit;
            if (upd_req) begin
                staging <= upd_data;
            end
            if (commit) begin
                shadow  <= upd_req ? upd_data : staging;
                pending <= 1'b0;
            end else if (upd_req) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
// Bench for display_scan_ctrl with CLK_DIV=4, NUM_DIG=8 (32-cycle frame).
// The reference model works from the number of clock edges since reset
// release: the output after edge n shows digit ((n-1)/4)%8, and a frame ends
// on edges that are multiples of 32.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

    localparam int CLK_DIV = 4;
    localparam int NUM_DIG = 8;
    localparam int FRAME   = CLK_DIV * NUM_DIG;
`ifdef SCAN_LZS_EN
    localparam bit LZS = 1'b1;
`else
    localparam bit LZS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        upd_req;
    logic [31:0] upd_data;
    logic [7:0]  blank;
    logic        upd_ack;
    logic [7:0]  DN_A;
    logic [3:0]  DIG;

    display_scan_ctrl #(
        .CLK_DIV (CLK_DIV),
        .NUM_DIG (NUM_DIG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .upd_req  (upd_req),
        .upd_data (upd_data),
        .blank    (blank),
        .upd_ack  (upd_ack),
        .DN_A     (DN_A),
        .DIG      (DIG)
    );

    always #5 clk = ~clk;

    int errors  = 0;
    int checks  = 0;
    int t       = 0;   // edges since reset release
    int m_idx   = 0;   // digit shown after the latest edge
    int ack_cnt = 0;
    logic [31:0] m_shadow  = '0;
    logic [31:0] m_staging = '0;
    logic        m_pending = 1'b0;

    typedef struct {
        int         edge_n;
        logic [7:0] dn_a;
        logic [3:0] dig;
    } vec_t;
    vec_t vec[12];

    logic [3:0] seq_a[8] = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};
    logic [3:0] seq_b[8] = '{4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (edge %0d): got %h expected %h", name, t, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_anode(input int k, input logic e,
                                             input logic [7:0] bl, input logic [31:0] sh);
        logic       off;
        int         hi;
        logic [7:0] a;
        hi = 0;
        for (int j = 0; j < 8; j++) begin
            if (sh[4*j +: 4] != 4'h0) hi = j;
        end
        off = bl[k];
        if (LZS && k > 0 && k > hi) off = 1'b1;
        a = 8'hFF;
        if (e && !off && k < NUM_DIG) a[k] = 1'b0;
        return a;
    endfunction

    // One clock: inputs were set before this posedge; model updates, outputs
    // compared 1 time unit after the edge, returns on the following negedge.
    task automatic step();
        logic       fe;
        logic       exp_ack;
        logic [7:0] ea;
        logic [3:0] ed;
        @(posedge clk);
        m_idx = (t / CLK_DIV) % NUM_DIG;
        fe    = (t % FRAME) == FRAME - 1;
        ea    = exp_anode(m_idx, en, blank, m_shadow);
        ed    = m_shadow[4*m_idx +: 4];
        exp_ack = 1'b0;
        if (fe && (m_pending || upd_req)) begin
            m_shadow  = upd_req ? upd_data : m_staging;
            m_pending = 1'b0;
            exp_ack   = 1'b1;
        end else if (upd_req) begin
            m_staging = upd_data;
            m_pending = 1'b1;
        end
        t++;
        #1;
        chk("dn_a", {24'h0, DN_A}, {24'h0, ea});
        chk("dig", {28'h0, DIG}, {28'h0, ed});
        chk("upd_ack", {31'h0, upd_ack}, {31'h0, exp_ack});
        if (upd_ack === 1'b1) ack_cnt++;
        @(negedge clk);
    endtask

    task automatic model_reset();
        t = 0;
        m_shadow  = '0;
        m_staging = '0;
        m_pending = 1'b0;
    endtask

    task automatic wait_commit(input string name);
        int n;
        n = 0;
        ack_cnt = 0;
        while (ack_cnt == 0 && n < 2 * FRAME) begin
            step();
            n++;
        end
        chk(name, ack_cnt, 1);
    endtask

    initial begin
        logic [7:0] lit;

        vec[0]  = '{1,  8'hFE, 4'h0};
        vec[1]  = '{4,  8'hFE, 4'h0};
        vec[2]  = '{5,  8'hFD, 4'h0};
        vec[3]  = '{8,  8'hFD, 4'h0};
        vec[4]  = '{9,  8'hFB, 4'h0};
        vec[5]  = '{13, 8'hF7, 4'h0};
        vec[6]  = '{17, 8'hEF, 4'h0};
        vec[7]  = '{21, 8'hDF, 4'h0};
        vec[8]  = '{25, 8'hBF, 4'h0};
        vec[9]  = '{29, 8'h7F, 4'h0};
        vec[10] = '{32, 8'h7F, 4'h0};
        vec[11] = '{33, 8'hFE, 4'h0};

        // Reset state
        rst = 1'b0; en = 1'b1; upd_req = 1'b0; upd_data = '0; blank = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dn_a", {24'h0, DN_A}, 32'hFF);
        chk("rst_dig", {28'h0, DIG}, 32'h0);
        chk("rst_ack", {31'h0, upd_ack}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // Scan order and first-tick latency from the table
        for (int i = 0; i < 12; i++) begin
            while (t < vec[i].edge_n) step();
            chk("tbl_dn_a", {24'h0, DN_A}, {24'h0, vec[i].dn_a});
            chk("tbl_dig", {28'h0, DIG}, {28'h0, vec[i].dig});
        end

        // Mid-frame update: held until frame end, then F..8, one ack
        while (t < 40) step();
        upd_req = 1'b1; upd_data = 32'h89ABCDEF;
        ack_cnt = 0;
        step();
        upd_req = 1'b0;
        while (t < 97) begin
            step();
            if (t <= 64) chk("mid_hold", {28'h0, DIG}, 32'h0);
            if (t >= 65 && t <= 93 && (t - 65) % 4 == 0)
                chk("mid_seq", {28'h0, DIG}, {28'h0, seq_a[(t - 65) / 4]});
        end
        chk("mid_ack_cnt", ack_cnt, 1);

        // Update strobe on the exact frame_end cycle
        while (t < 127) step();
        upd_req = 1'b1; upd_data = 32'h12345678;
        ack_cnt = 0;
        step();
        upd_req = 1'b0;
        while (t < 161) begin
            step();
            if (t >= 129 && t <= 157 && (t - 129) % 4 == 0)
                chk("fe_seq", {28'h0, DIG}, {28'h0, seq_b[(t - 129) / 4]});
        end
        chk("fe_ack_cnt", ack_cnt, 1);

        // Blank mask with en dropped for 10 cycles
        blank = 8'h0F;
        repeat (6) step();
        en = 1'b0;
        repeat (10) begin
            step();
            chk("en_low", {24'h0, DN_A}, 32'hFF);
        end
        en = 1'b1;
        repeat (40) begin
            step();
            if (m_idx < 4) chk("blank_lo", {24'h0, DN_A}, 32'hFF);
        end
        blank = 8'h00;

        // Zero suppression patterns
        upd_req = 1'b1; upd_data = 32'h00000305;
        step();
        upd_req = 1'b0;
        wait_commit("lzs305_ack");
        repeat (FRAME) begin
            step();
            lit = 8'hFF;
            if (!LZS || m_idx <= 2) lit[m_idx] = 1'b0;
            chk("lzs305", {24'h0, DN_A}, {24'h0, lit});
        end
        upd_req = 1'b1; upd_data = 32'h0;
        step();
        upd_req = 1'b0;
        wait_commit("lzs0_ack");
        repeat (FRAME) begin
            step();
            lit = 8'hFF;
            if (!LZS || m_idx == 0) lit[m_idx] = 1'b0;
            chk("lzs0", {24'h0, DN_A}, {24'h0, lit});
        end

        // Randomized traffic against the model
        repeat (400) begin
            en       = ($urandom_range(0, 7) != 0);
            blank    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
            upd_req  = ($urandom_range(0, 5) == 0);
            upd_data = $urandom;
            step();
        end
        upd_req = 1'b0; en = 1'b1; blank = 8'h00;

        // Reset with an update pending
        while ((t % FRAME) > 20) step();
        upd_req = 1'b1; upd_data = 32'hA5A5A5A5;
        step();
        upd_req = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        #1;
        chk("arst_dn_a", {24'h0, DN_A}, 32'hFF);
        chk("arst_dig", {28'h0, DIG}, 32'h0);
        chk("arst_ack", {31'h0, upd_ack}, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("arst_hold", {24'h0, DN_A}, 32'hFF);
        @(negedge clk);
        rst = 1'b1;
        ack_cnt = 0;
        repeat (70) begin
            step();
            chk("post_rst_dig", {28'h0, DIG}, 32'h0);
        end
        chk("post_rst_ack", ack_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
